// File: rtl/sipo_rx_if.sv
// rtl/sipo_rx_if.sv - serial input and parallel word output bundle for sipo_rx
interface sipo_rx_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH + 1);

  logic             sdi;
  logic             cs;
  logic [WIDTH-1:0] pdo;
  logic             pdo_valid;
  logic             pdo_ready;
  logic [LW-1:0]    level;
  logic             overflow;
  logic             ovf_clr;
  logic             abort;

  modport master (
    output sdi, cs, pdo_ready, ovf_clr,
    input  pdo, pdo_valid, level, overflow, abort
  );

  modport slave (
    input  sdi, cs, pdo_ready, ovf_clr,
    output pdo, pdo_valid, level, overflow, abort
  );
endinterface

// File: rtl/sipo_rx.sv
// rtl/sipo_rx.sv - serial-in/parallel-out receiver with FWFT word FIFO
module sipo_rx #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  sipo_rx_if.slave  bus
);
  localparam int BW = $clog2(WIDTH);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [BW-1:0] BCNT_LAST = BW'(WIDTH - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);

  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [PW-1:0]    hptr_q, hptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             abort_q, abort_d;

  logic [WIDTH-1:0] shifted;
  logic             word_done;
  logic             pop;
  logic             push;
  logic             drop;
  logic             full;

  always_comb begin
    if (MSB_FIRST) begin
      shifted = {sr_q[WIDTH-2:0], bus.sdi};
    end else begin
      shifted = {bus.sdi, sr_q[WIDTH-1:1]};
    end
  end

  // A simultaneous pop frees the slot the completing word needs, so full only drops without one.
  always_comb begin
    word_done = bus.cs && (bcnt_q == BCNT_LAST);
    pop       = valid_q && bus.pdo_ready;
    full      = (level_q == LVL_FULL);
    push      = word_done && (!full || pop);
    drop      = word_done && full && !pop;
  end

  always_comb begin
    bcnt_d  = bcnt_q;
    sr_d    = sr_q;
    abort_d = 1'b0;
    if (bus.cs) begin
      sr_d   = shifted;
      bcnt_d = word_done ? '0 : bcnt_q + BW'(1);
    end else if (bcnt_q != '0) begin
      sr_d    = '0;
      bcnt_d  = '0;
      abort_d = 1'b1;
    end
  end

  always_comb begin
    wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + PW'(1) : rptr_q;
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    valid_d = (level_d != '0);
    // The head pointer freezes when the FIFO drains so pdo keeps showing the last word.
    hptr_d  = valid_d ? rptr_d : hptr_q;
    ovf_d   = drop | (ovf_q & ~bus.ovf_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt_q  <= '0;
      sr_q    <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      hptr_q  <= '0;
      level_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      abort_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      bcnt_q  <= bcnt_d;
      sr_q    <= sr_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      hptr_q  <= hptr_d;
      level_q <= level_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      abort_q <= abort_d;
      if (push) begin
        mem_q[wptr_q] <= shifted;
      end
    end
  end

  assign bus.pdo       = mem_q[hptr_q];
  assign bus.pdo_valid = valid_q;
  assign bus.level     = level_q;
  assign bus.overflow  = ovf_q;
  assign bus.abort     = abort_q;
endmodule

// File: doc/sipo_rx.md
# sipo_rx

Parametrised serial-in/parallel-out receiver for the Ascon SPI link: shifts `sdi` in one bit per `clk` edge while `cs` is high, assembles `WIDTH`-bit words, and queues them in a `DEPTH`-entry first-word-fall-through FIFO. Compared with the fixed 32-bit converter, it adds:

- selectable bit order;
- a valid/ready output handshake;
- buffering;
- overflow detection;
- abort reporting for frames cut short by `cs`.

It sits between the SPI pins and the Ascon input datapath.

## Interface

Parameters:

- `WIDTH`, default 32, word size in bits (≥2).
- `DEPTH`, default 4, FIFO entries (power of two, ≥2).
- `MSB_FIRST`, default 1. When 1, the first received bit lands in `pdo[WIDTH-1]`; when 0, it lands in `pdo[0]`.

Ports:

- `clk`  in  1  system clock; every register updates on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `sdi`  in  1  serial data, sampled on the `clk` rising edge when `cs`=1.
- `cs`  in  1  chip select, active-high; 1 = shifting.
- `pdo`  out  WIDTH  FIFO head word; holds the last value when empty.
- `pdo_valid`  out  1  FIFO non-empty.
- `pdo_ready`  in  1  consumer accepts head; pop occurs when `pdo_valid`&`pdo_ready`.
- `level`  out  $clog2(DEPTH+1)  number of words stored.
- `overflow`  out  1  sticky: a completed word was dropped.
- `ovf_clr`  in  1  clears `overflow`.
- `abort`  out  1  one-cycle pulse: `cs` fell with a partial word pending.

## Operation

- **Bit counter** `bcnt`, 0..WIDTH-1.
  - On an edge with `cs`=1: the shift register takes `sdi` and `bcnt` increments.
  - If `bcnt`==WIDTH-1 on that edge, the edge completes a word and `bcnt` wraps to 0.
- **Shift direction**
  - `MSB_FIRST`=1: the new value is {sr[WIDTH-2:0], sdi}.
  - `MSB_FIRST`=0: the new value is {sdi, sr[WIDTH-1:1]}.
  - The completed word is the post-shift value. It includes the bit sampled on the completing edge.
- **Push** occurs on a completing edge when `level`<DEPTH, or when a pop happens on the same edge. Simultaneous push and pop at full is legal and leaves `level`=DEPTH.
- **Drop**: on a completing edge with `level`==DEPTH and no pop, the word is discarded and `overflow` is set.
  - `overflow` is cleared only by `rst` or `ovf_clr`.
  - If `ovf_clr` and a new drop occur on the same edge, set wins.
- **Partial-word abort**: on an edge with `cs`=0 and `bcnt`≠0, the partial word is discarded, `bcnt` goes to 0, and `abort`=1 for exactly one cycle.
  - With `cs`=0 and `bcnt`=0, nothing changes.
- **Pop on empty** (`pdo_ready`=1, `pdo_valid`=0) is ignored and `level` stays 0.
- **Pointers** are `$clog2(DEPTH)` bits wide and wrap modulo DEPTH. `level` is tracked separately so that full and empty are distinguishable.
- **Reset** (`rst`=1 on an edge), including mid-frame, produces these values:
  - `pdo`=0, `pdo_valid`=0, `level`=0, `overflow`=0, `abort`=0;
  - `bcnt`=0, shift register=0, pointers=0;
  - stored words are lost.
  - `rst` has priority over all other inputs.
  - If `cs` is still high after `rst` falls, the first edge with `rst`=0 samples bit 0 of a new word.

## Timing

- **Latency**: a word completed on edge N gives `pdo_valid`=1 with that word on `pdo` after edge N, when the FIFO was empty. The consumer can pop it on edge N+1.
- **Head update**: a pop on edge M moves the next word to `pdo` after edge M. This happens in the same cycle, with no bubble.
- **Throughput**: back-to-back words with `cs` held high need no idle bits. One word completes every WIDTH cycles.
- **Outputs**: `level`, `overflow`, `abort` and `pdo_valid` are all registered. `pdo` is the FIFO head, read from a register array indexed by a registered pointer; it has no combinational path from inputs.
- **Handshake rule**: once `pdo_valid`=1, the head word stays stable until it is popped.

## Test plan

- **Single MSB-first word**: WIDTH=32, MSB_FIRST=1; reset, then shift 0xA5C3_0F81 MSB first with `cs` high for 32 cycles, `pdo_ready`=0. Expected: after the 32nd edge `pdo`=0xA5C30F81, `pdo_valid`=1, `level`=1. After one cycle with `pdo_ready`=1: `pdo_valid`=0, `level`=0.
- **LSB-first, narrow width**: WIDTH=8, MSB_FIRST=0; shift bits 1,0,0,0,0,0,0,0. Expected: `pdo`=0x01. The same bits with MSB_FIRST=1 give `pdo`=0x80.
- **Fill and overflow**: DEPTH=4; stream 5 words 0x1..0x5 back-to-back with `pdo_ready`=0. Expected: `level`=4 and `overflow`=1 after the 5th word. Pops return 0x1,0x2,0x3,0x4; 0x5 is absent. Pulsing `ovf_clr` gives `overflow`=0.
- **Push and pop at full**: with `level`=4, hold `pdo_ready`=1 across the completing edge of a 5th word. Expected: `overflow` stays 0, `level` stays 4, and the 5th word is returned last.
- **Abort**: drop `cs` after 13 bits. Expected: `abort` high for exactly one cycle, `level` unchanged. The next full 32-bit frame is received intact.
- **Reset mid-frame**: assert `rst` for one cycle after 20 bits with 2 words queued and `overflow`=1. Expected: all outputs are 0 on the next cycle. With `cs` still high, the next 32 bits form a correct word.
